// File: rtl/ide_pio_ctrl.sv
// ============================================================================
// Module      : ide_pio_ctrl
// Description : Host-side ATA/IDE PIO register-access controller. Turns one
//               local-bus read/write request into a timed IDE cycle (CS/DA
//               setup, DIOR-/DIOW- pulse, hold) with a level done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ide_pio_ctrl #(
  parameter int SETUP_CYCLES = 4,   // CS/DA valid to strobe assertion
  parameter int PULSE_CYCLES = 9,   // strobe low time, must be >= 1
  parameter int HOLD_CYCLES  = 2    // strobe release to done, must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ata_rd,
  input  logic        ata_wr,
  input  logic [4:0]  ata_addr,
  input  logic [15:0] ata_in,
  output logic [15:0] ata_out,
  output logic        ata_done,
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } ata_state_t;

  // ata_state keeps its bare name so it can be probed hierarchically.
  ata_state_t       ata_state;
  ata_state_t       ata_state_d;

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             is_rd_q,  is_rd_d;
  logic [1:0]       cs_q,     cs_d;
  logic [2:0]       da_q,     da_d;
  logic [15:0]      wdata_q,  wdata_d;
  logic             bus_oe_q, bus_oe_d;
  logic             dior_q,   dior_d;
  logic             diow_q,   diow_d;
  logic [15:0]      rdata_q,  rdata_d;
  logic             done_q,   done_d;

  // All IDE-facing outputs come straight from flops so they never glitch.
  assign ide_data_bus = bus_oe_q ? wdata_q : 16'hzzzz;
  assign ide_dior     = dior_q;
  assign ide_diow     = diow_q;
  assign ide_cs       = cs_q;
  assign ide_da       = da_q;
  assign ata_out      = rdata_q;
  assign ata_done     = done_q;

  // State register and datapath flops; reset abandons any cycle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ata_state <= ST_IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      cs_q      <= 2'b11;
      da_q      <= 3'd0;
      wdata_q   <= 16'h0000;
      bus_oe_q  <= 1'b0;
      dior_q    <= 1'b1;
      diow_q    <= 1'b1;
      rdata_q   <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      ata_state <= ata_state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      cs_q      <= cs_d;
      da_q      <= da_d;
      wdata_q   <= wdata_d;
      bus_oe_q  <= bus_oe_d;
      dior_q    <= dior_d;
      diow_q    <= diow_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; every phase counts down to zero.
  always_comb begin
    ata_state_d = ata_state;
    cnt_d       = cnt_q;
    is_rd_d     = is_rd_q;
    cs_d        = cs_q;
    da_d        = da_q;
    wdata_d     = wdata_q;
    bus_oe_d    = bus_oe_q;
    dior_d      = dior_q;
    diow_d      = diow_q;
    rdata_d     = rdata_q;
    done_d      = done_q;

    case (ata_state)
      ST_IDLE: begin
        if (ata_rd || ata_wr) begin
          // Read wins when both requests are raised together.
          is_rd_d     = ata_rd;
          cs_d        = ata_addr[4:3];
          da_d        = ata_addr[2:0];
          if (!ata_rd) begin
            wdata_d  = ata_in;
            bus_oe_d = 1'b1;
          end
          cnt_d       = CNT_W'(SETUP_CYCLES);
          ata_state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          if (is_rd_q) begin
            dior_d = 1'b0;
          end else begin
            diow_d = 1'b0;
          end
          cnt_d       = CNT_W'(PULSE_CYCLES - 1);
          ata_state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_PULSE: begin
        if (cnt_q == '0) begin
          // Sample the drive's data while DIOR- is still low on this edge.
          if (is_rd_q) begin
            rdata_d = ide_data_bus;
          end
          dior_d      = 1'b1;
          diow_d      = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
          ata_state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs_d        = 2'b11;
          bus_oe_d    = 1'b0;
          done_d      = 1'b1;
          ata_state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Wait for the requester to drop both levels before re-arming.
        if (!ata_rd && !ata_wr) begin
          done_d      = 1'b0;
          ata_state_d = ST_IDLE;
        end
      end

      default: begin
        dior_d      = 1'b1;
        diow_d      = 1'b1;
        cs_d        = 2'b11;
        bus_oe_d    = 1'b0;
        done_d      = 1'b0;
        ata_state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ide_pio_ctrl.sv
// ============================================================================
// Module      : tb_ide_pio_ctrl
// Description : Self-checking bench for ide_pio_ctrl with a behavioural IDE
//               drive model and a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ide_pio_ctrl;

  localparam int S = 4;
  localparam int P = 9;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ata_rd, ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out;
  logic        ata_done;
  wire  [15:0] ide_data_bus;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic [15:0] model_rdata;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_out;

  always #5 clk = ~clk;

  // Drive model: answers with model_rdata whenever DIOR- is low.
  assign ide_data_bus = ide_dior ? 16'hzzzz : model_rdata;

  ide_pio_ctrl #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .ata_rd(ata_rd), .ata_wr(ata_wr),
    .ata_addr(ata_addr), .ata_in(ata_in), .ata_out(ata_out),
    .ata_done(ata_done), .ide_data_bus(ide_data_bus), .ide_dior(ide_dior),
    .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da)
  );

  // Reference timeline, counted in negedge samples after the accepting edge
  // E (sample k follows edge E+k-1). Strobe asserts at edge E+1+S.
  function automatic int exp_strobe_first(); return S + 2; endfunction
  function automatic int exp_done_k();       return S + P + H + 2; endfunction
  function automatic int exp_oe_samples();   return S + P + H + 1; endfunction

  typedef struct {
    int          rd_first, rd_cnt, wr_first, wr_cnt;
    int          done_k, oe_cnt, bus_bad, illegal, cs_unstable;
    logic [1:0]  cs1, cs_str;
    logic [2:0]  da1, da_str;
    logic [15:0] out;
  } obs_t;

  // Issues one request and records what the IDE side does until done.
  task automatic run_req(input logic rd, input logic wr, input logic [4:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata,
                         output obs_t o);
    o = '{rd_first: -1, rd_cnt: 0, wr_first: -1, wr_cnt: 0, done_k: -1,
          oe_cnt: 0, bus_bad: 0, illegal: 0, cs_unstable: 0,
          cs1: 2'b00, cs_str: 2'b00, da1: 3'd0, da_str: 3'd0, out: 16'h0};
    @(negedge clk);
    ata_rd = rd; ata_wr = wr; ata_addr = addr; ata_in = wdata;
    model_rdata = rdata;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin o.cs1 = ide_cs; o.da1 = ide_da; end
      if (!ata_done && ide_cs != o.cs1) o.cs_unstable++;
      if (!ide_dior) begin
        if (o.rd_first < 0) begin o.rd_first = k; o.cs_str = ide_cs; o.da_str = ide_da; end
        o.rd_cnt++;
      end
      if (!ide_diow) begin
        if (o.wr_first < 0) begin o.wr_first = k; o.cs_str = ide_cs; o.da_str = ide_da; end
        o.wr_cnt++;
        if (ide_data_bus !== wdata) o.bus_bad++;
      end
      if ((!ide_dior && !ide_diow) || ((!ide_dior || !ide_diow) && ide_cs == 2'b11))
        o.illegal++;
      if (dut.bus_oe_q) o.oe_cnt++;
      if (ata_done) begin o.done_k = k; break; end
    end
    o.out = ata_out;
  endtask

  // Keeps the request up for 'extra' clocks after done, then drops it.
  task automatic release_req(input int extra, output int done_seen,
                             output int strobes, output logic done_after,
                             output logic [2:0] state_after);
    done_seen = 0; strobes = 0;
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      if (ata_done) done_seen++;
      if (!ide_dior || !ide_diow) strobes++;
    end
    ata_rd = 1'b0; ata_wr = 1'b0;
    @(negedge clk);
    done_after  = ata_done;
    state_after = dut.ata_state;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ata_rd = 0; ata_wr = 0; ata_addr = 0; ata_in = 0; model_rdata = 0;
    repeat (3) @(negedge clk);
    checks++; if (dut.ata_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dut.ata_state); end
    checks++; if ({ide_dior, ide_diow} !== 2'b11) begin errors++; $display("FAIL reset_strobes got %b want 11", {ide_dior, ide_diow}); end
    checks++; if (ide_cs !== 2'b11 || ide_da !== 3'd0) begin errors++; $display("FAIL reset_csda got %b/%0d want 11/0", ide_cs, ide_da); end
    checks++; if (ata_out !== 16'h0 || ata_done !== 1'b0 || dut.bus_oe_q !== 1'b0) begin errors++; $display("FAIL reset_out got out=%h done=%b oe=%b want 0/0/0", ata_out, ata_done, dut.bus_oe_q); end
    rst_n = 1'b1;
    exp_out = 16'h0000;
  endtask

  task automatic test_read_status();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    run_req(1'b1, 1'b0, 5'b10111, 16'h0, 16'h0050, o);
    exp_out = 16'h0050;
    checks++; if (o.cs1 !== 2'b10 || o.da1 !== 3'd7) begin errors++; $display("FAIL status_csda got %b/%0d want 10/7", o.cs1, o.da1); end
    checks++; if (o.rd_first != exp_strobe_first() || o.rd_cnt != P) begin errors++; $display("FAIL status_dior got first=%0d len=%0d want %0d/%0d", o.rd_first, o.rd_cnt, exp_strobe_first(), P); end
    checks++; if (o.done_k != exp_done_k()) begin errors++; $display("FAIL status_done got %0d want %0d", o.done_k, exp_done_k()); end
    checks++; if (o.out !== exp_out) begin errors++; $display("FAIL status_data got %h want %h", o.out, exp_out); end
    release_req(0, ds, st, da, sa);
    checks++; if (da !== 1'b0 || sa !== 3'd0) begin errors++; $display("FAIL status_idle got done=%b state=%0d want 0/0", da, sa); end
  endtask

  task automatic test_reads();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    for (int a = 1; a <= 6; a++) begin
      run_req(1'b1, 1'b0, {2'b10, 3'(a)}, 16'hFFFF, 16'h0000, o);
      exp_out = 16'h0000;
      checks++; if (o.out !== exp_out || o.da_str !== 3'(a)) begin errors++; $display("FAIL reads_%0d got out=%h da=%0d want %h/%0d", a, o.out, o.da_str, exp_out, a); end
      checks++; if (o.wr_cnt != 0 || o.rd_cnt != P) begin errors++; $display("FAIL reads_strobe_%0d got wr=%0d rd=%0d want 0/%0d", a, o.wr_cnt, o.rd_cnt, P); end
      release_req(0, ds, st, da, sa);
    end
  endtask

  task automatic test_writes();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    for (int v = 0; v < 3; v++) begin
      run_req(1'b0, 1'b1, 5'b10000, 16'(v), 16'h1234, o);
      checks++; if (o.wr_first != exp_strobe_first() || o.wr_cnt != P || o.rd_cnt != 0) begin errors++; $display("FAIL write_%0d_strobe got first=%0d wr=%0d rd=%0d want %0d/%0d/0", v, o.wr_first, o.wr_cnt, o.rd_cnt, exp_strobe_first(), P); end
      checks++; if (o.bus_bad != 0 || o.oe_cnt != exp_oe_samples()) begin errors++; $display("FAIL write_%0d_bus got bad=%0d oe=%0d want 0/%0d", v, o.bus_bad, o.oe_cnt, exp_oe_samples()); end
      checks++; if (o.out !== exp_out || dut.bus_oe_q !== 1'b0) begin errors++; $display("FAIL write_%0d_after got out=%h oe=%b want %h/0", v, o.out, dut.bus_oe_q, exp_out); end
      release_req(0, ds, st, da, sa);
    end
  endtask

  task automatic test_hold_request();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    run_req(1'b1, 1'b0, 5'b10010, 16'h0, 16'hA5A5, o);
    exp_out = 16'hA5A5;
    release_req(50, ds, st, da, sa);
    checks++; if (ds != 50 || st != 0) begin errors++; $display("FAIL hold_req got done=%0d strobes=%0d want 50/0", ds, st); end
    checks++; if (da !== 1'b0 || sa !== 3'd0) begin errors++; $display("FAIL hold_idle got done=%b state=%0d want 0/0", da, sa); end
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    ata_wr = 1'b1; ata_addr = 5'b10000; ata_in = 16'hBEEF;
    repeat (S + 4) @(negedge clk);
    checks++; if (ide_diow !== 1'b0) begin errors++; $display("FAIL rst_pre got diow=%b want 0", ide_diow); end
    #2 rst_n = 1'b0;
    #1;
    exp_out = 16'h0000;
    checks++; if (ide_diow !== 1'b1 || ide_dior !== 1'b1 || ide_cs !== 2'b11) begin errors++; $display("FAIL rst_async got dior=%b diow=%b cs=%b want 1/1/11", ide_dior, ide_diow, ide_cs); end
    checks++; if (dut.bus_oe_q !== 1'b0 || ata_done !== 1'b0 || dut.ata_state !== 3'd0 || ata_out !== exp_out) begin errors++; $display("FAIL rst_state got oe=%b done=%b state=%0d out=%h want 0/0/0/0", dut.bus_oe_q, ata_done, dut.ata_state, ata_out); end
    ata_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_both_requests();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    run_req(1'b1, 1'b1, 5'b10011, 16'h7777, 16'h3C3C, o);
    exp_out = 16'h3C3C;
    checks++; if (o.wr_cnt != 0 || o.rd_cnt != P || o.out !== exp_out) begin errors++; $display("FAIL both_req got wr=%0d rd=%0d out=%h want 0/%0d/%h", o.wr_cnt, o.rd_cnt, o.out, P, exp_out); end
    release_req(0, ds, st, da, sa);
  endtask

  task automatic test_random();
    obs_t o; int ds, st; logic da; logic [2:0] sa;
    logic rd, wr; logic [4:0] addr; logic [15:0] wd, rdv; int extra;
    for (int n = 0; n < 16; n++) begin
      rd    = 1'($urandom_range(0, 1));
      wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr  = {($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 3'($urandom_range(0, 7))};
      wd    = 16'($urandom); rdv = 16'($urandom);
      extra = $urandom_range(0, 3);
      run_req(rd, wr, addr, wd, rdv, o);
      if (rd) exp_out = rdv;
      checks++; if (o.cs1 !== addr[4:3] || o.da1 !== addr[2:0] || o.cs_unstable != 0) begin errors++; $display("FAIL rnd_%0d_addr got cs=%b da=%0d unst=%0d want %b/%0d/0", n, o.cs1, o.da1, o.cs_unstable, addr[4:3], addr[2:0]); end
      checks++; if ((rd ? o.rd_first : o.wr_first) != exp_strobe_first() || (rd ? o.rd_cnt : o.wr_cnt) != P || (rd ? o.wr_cnt : o.rd_cnt) != 0) begin errors++; $display("FAIL rnd_%0d_strobe got rd=%0d/%0d wr=%0d/%0d", n, o.rd_first, o.rd_cnt, o.wr_first, o.wr_cnt); end
      checks++; if (o.done_k != exp_done_k() || o.illegal != 0) begin errors++; $display("FAIL rnd_%0d_done got k=%0d illegal=%0d want %0d/0", n, o.done_k, o.illegal, exp_done_k()); end
      checks++; if (o.oe_cnt != (rd ? 0 : exp_oe_samples()) || o.bus_bad != 0) begin errors++; $display("FAIL rnd_%0d_bus got oe=%0d bad=%0d", n, o.oe_cnt, o.bus_bad); end
      checks++; if (o.out !== exp_out) begin errors++; $display("FAIL rnd_%0d_data got %h want %h", n, o.out, exp_out); end
      release_req(extra, ds, st, da, sa);
      checks++; if (ds != extra || st != 0 || da !== 1'b0 || sa !== 3'd0) begin errors++; $display("FAIL rnd_%0d_release got done=%0d strobes=%0d after=%b state=%0d", n, ds, st, da, sa); end
    end
  endtask

  initial begin
    test_reset();
    test_read_status();
    test_reads();
    test_writes();
    test_hold_request();
    test_reset_mid_pulse();
    test_both_requests();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
